// File: rtl/high_pass_moving_avg.sv
// high_pass_moving_avg: subtracts a power-of-two moving-window average from a
// centre-delayed copy of the input. The first stage updates the window, the
// running sum and the fill state. The second stage registers a saturated
// high-pass sample together with a one-cycle valid pulse.
module high_pass_moving_avg #(
  parameter int DATA_WIDTH  = 16,
  parameter int LOG2_WINDOW = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         out_valid,
  output logic                         primed
);

  localparam int N  = 1 << LOG2_WINDOW;
  localparam int AW = DATA_WIDTH + LOG2_WINDOW;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Sign-extend a sample to accumulator width.
  function automatic logic signed [AW-1:0] sext_acc(input logic signed [DATA_WIDTH-1:0] x);
    sext_acc = {{LOG2_WINDOW{x[DATA_WIDTH-1]}}, x};
  endfunction

  // Clamp a (DATA_WIDTH+1)-bit difference into the DATA_WIDTH signed range.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH:0] v);
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1]) begin
      if (v[DATA_WIDTH]) begin
        saturate = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        saturate = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      saturate = v[DATA_WIDTH-1:0];
    end
  endfunction

  logic signed [DATA_WIDTH-1:0]  d_r [N];
  logic signed [AW-1:0]          sum_r;
  logic [LOG2_WINDOW-1:0]        fill_cnt_r;
  state_t                        state_r;
  logic                          pend_valid_r;

  logic                          accept_s;
  logic signed [DATA_WIDTH-1:0]  avg_s;
  logic signed [DATA_WIDTH-1:0]  centre_s;
  logic signed [DATA_WIDTH:0]    hp_s;

  // A clear in the same cycle as a strobe discards the sample.
  assign accept_s = enable & ~clear;

  // Average and high-pass difference from the window as it stands after the update.
  always_comb begin
    // Upper bits of the sum are the arithmetic right shift by LOG2_WINDOW.
    avg_s    = sum_r[AW-1:LOG2_WINDOW];
    centre_s = d_r[N/2];
    hp_s     = {centre_s[DATA_WIDTH-1], centre_s} - {avg_s[DATA_WIDTH-1], avg_s};
  end

  // Delay line and running sum; the sum is wide enough to never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      for (int i = 0; i < N; i++) d_r[i] <= '0;
    end else if (clear) begin
      sum_r <= '0;
      for (int i = 0; i < N; i++) d_r[i] <= '0;
    end else if (accept_s) begin
      sum_r <= sum_r + sext_acc(sample_in) - sext_acc(d_r[N-1]);
      d_r[0] <= sample_in;
      for (int i = 1; i < N; i++) d_r[i] <= d_r[i-1];
    end else begin
      sum_r <= sum_r;
    end
  end

  // Fill/run state machine; raises primed and flags samples that produce output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FILL;
      fill_cnt_r   <= '0;
      primed       <= 1'b0;
      pend_valid_r <= 1'b0;
    end else if (clear) begin
      state_r      <= FILL;
      fill_cnt_r   <= '0;
      primed       <= 1'b0;
      pend_valid_r <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s && (fill_cnt_r == LOG2_WINDOW'(N - 1))) begin
            state_r      <= RUN;
            fill_cnt_r   <= '0;
            primed       <= 1'b1;
            pend_valid_r <= 1'b1;
          end else if (accept_s) begin
            fill_cnt_r   <= fill_cnt_r + LOG2_WINDOW'(1);
            pend_valid_r <= 1'b0;
          end else begin
            pend_valid_r <= 1'b0;
          end
        end
        RUN: begin
          pend_valid_r <= accept_s;
        end
        default: begin
          state_r      <= FILL;
          fill_cnt_r   <= '0;
          primed       <= 1'b0;
          pend_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Output register: saturated high-pass sample plus one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else if (clear) begin
      out_valid  <= 1'b0;
    end else if (pend_valid_r) begin
      sample_out <= saturate(hp_s);
      out_valid  <= 1'b1;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule
